// File: rtl/ball_engine.sv
// Brick-breaker ball engine: moves a square ball once per movement tick, reflects off
// paddle, blocks and walls, and runs the serve / lost sequencing for the VGA path.
module ball_engine #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned BALL_SIZE  = 20,
    parameter int unsigned TICK_DIV   = 416667,
    parameter int unsigned NUM_BLOCKS = 10,
    parameter int unsigned START_X    = 310,
    parameter int unsigned START_Y    = 400,
    parameter int unsigned LOST_TICKS = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  active_pixels,
    input  logic                  serve,
    input  logic [1:0]            speed_sel,
    input  logic                  collide_paddle,
    input  logic [NUM_BLOCKS-1:0] collide_blocks,
    input  logic                  collide_side,
    output logic [23:0]           vga_color,
    output logic                  in_ball,
    output logic [9:0]            ball_x,
    output logic [9:0]            ball_y,
    output logic [9:0]            ball_size,
    output logic [1:0]            state,
    output logic                  ball_lost,
    output logic                  tick
);

    localparam int unsigned CW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LW    = (LOST_TICKS > 2) ? $clog2(LOST_TICKS) : 1;
    localparam int unsigned MAX_X = SCREEN_W - BALL_SIZE;
    localparam int unsigned MAX_Y = SCREEN_H - BALL_SIZE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_LOST = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic [LW-1:0]   lost_cnt_q, lost_cnt_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            left_q, left_d;     // 0 = moving right
    logic            down_q, down_d;     // 0 = moving up
    logic [2:0]      v_q, v_d;
    logic            pad_q, pad_d, blk_q, blk_d, side_q, side_d;
    logic            lost_q, lost_d;
    logic [10:0]     nx, ny, vs;
    logic            ndx, ndy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            lost_cnt_q <= '0;
            x_q        <= 10'(START_X);
            y_q        <= 10'(START_Y);
            left_q     <= 1'b0;
            down_q     <= 1'b0;
            v_q        <= 3'd1;
            pad_q      <= 1'b0;
            blk_q      <= 1'b0;
            side_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            lost_cnt_q <= lost_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            left_q     <= left_d;
            down_q     <= down_d;
            v_q        <= v_d;
            pad_q      <= pad_d;
            blk_q      <= blk_d;
            side_q     <= side_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lost_cnt_d = lost_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        left_d     = left_q;
        down_d     = down_q;
        v_d        = v_q;
        lost_d     = 1'b0;
        nx         = {1'b0, x_q};
        ny         = {1'b0, y_q};
        vs         = 11'(v_q);
        ndx        = left_q;
        ndy        = down_q;

        // tick_q is high exactly while cnt_q sits at TICK_DIV-1
        cnt_d  = tick_q ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == CW'(TICK_DIV - 1));

        // A hit seen in the tick cycle itself is carried into the next period
        pad_d  = tick_q ? collide_paddle   : (pad_q  | collide_paddle);
        blk_d  = tick_q ? |collide_blocks  : (blk_q  | (|collide_blocks));
        side_d = tick_q ? collide_side     : (side_q | collide_side);

        unique case (state_q)
            S_IDLE: begin
                x_d = 10'(START_X);
                y_d = 10'(START_Y);
                if (serve) begin
                    state_d = S_MOVE;
                    v_d     = 3'({1'b0, speed_sel}) + 3'd1;
                    left_d  = 1'b0;
                    down_d  = 1'b0;
                end
            end
            S_MOVE: begin
                if (tick_q) begin
                    if (pad_q && down_q)      ndy = 1'b0;
                    else if (blk_q && !side_q) ndy = ~down_q;
                    if (blk_q && side_q)      ndx = ~left_q;

                    // Wall handling runs after collisions and overrides them
                    if (!ndx) begin
                        nx = {1'b0, x_q} + vs;
                        if (nx >= 11'(MAX_X)) begin
                            nx  = 11'(MAX_X);
                            ndx = 1'b1;
                        end
                    end else if ({1'b0, x_q} <= vs) begin
                        nx  = '0;
                        ndx = 1'b0;
                    end else begin
                        nx = {1'b0, x_q} - vs;
                    end

                    if (!ndy) begin
                        if ({1'b0, y_q} <= vs) begin
                            ny  = '0;
                            ndy = 1'b1;
                        end else begin
                            ny = {1'b0, y_q} - vs;
                        end
                    end else begin
                        ny = {1'b0, y_q} + vs;
                        if (ny >= 11'(MAX_Y)) begin
                            ny      = 11'(MAX_Y);
                            state_d = S_LOST;
                            lost_d  = 1'b1;
                        end
                    end

                    x_d    = nx[9:0];
                    y_d    = ny[9:0];
                    left_d = ndx;
                    down_d = ndy;
                end
            end
            S_LOST: begin
                if (tick_q) begin
                    if (lost_cnt_q == LW'(LOST_TICKS - 1)) begin
                        state_d    = S_IDLE;
                        lost_cnt_d = '0;
                        x_d        = 10'(START_X);
                        y_d        = 10'(START_Y);
                        left_d     = 1'b0;
                        down_d     = 1'b0;
                    end else begin
                        lost_cnt_d = lost_cnt_q + LW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Display decode straight from the position registers
    always_comb begin
        in_ball = active_pixels
                  && (x >= x_q) && ({1'b0, x} < ({1'b0, x_q} + 11'(BALL_SIZE)))
                  && (y >= y_q) && ({1'b0, y} < ({1'b0, y_q} + 11'(BALL_SIZE)));
        if (!in_ball)               vga_color = 24'h000000;
        else if (state_q == S_LOST) vga_color = 24'hFF0000;
        else                        vga_color = 24'hFFFFFF;
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign ball_size = 10'(BALL_SIZE);
    assign state     = state_q;
    assign ball_lost = lost_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with a 4-cycle movement tick; positions are
// hand-traced tick by tick from the park position.
module tb_ball_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        active_pixels, serve, collide_paddle, collide_side;
    logic [1:0]  speed_sel;
    logic [9:0]  collide_blocks;
    logic [23:0] vga_color;
    logic        in_ball, ball_lost, tick;
    logic [9:0]  ball_x, ball_y, ball_size;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    ball_engine #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
        .serve(serve), .speed_sel(speed_sel), .collide_paddle(collide_paddle),
        .collide_blocks(collide_blocks), .collide_side(collide_side),
        .vga_color(vga_color), .in_ball(in_ball), .ball_x(ball_x), .ball_y(ball_y),
        .ball_size(ball_size), .state(state), .ball_lost(ball_lost), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int ex, input int ey);
        check_eq({tag, "_x"}, 32'(ball_x), 32'(ex));
        check_eq({tag, "_y"}, 32'(ball_y), 32'(ey));
    endtask

    // Advance past n movement ticks; ends on the falling edge after the last one.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (tick !== 1'b1 && guard < 16) begin
                @(negedge clk);
                guard++;
            end
            if (tick !== 1'b1) begin
                check_eq("tick_timeout", 32'(tick), 32'd1);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_serve(input logic [1:0] sel);
        serve     = 1'b1;
        speed_sel = sel;
        @(negedge clk);
        serve     = 1'b0;
        speed_sel = 2'd0;
    endtask

    task automatic pulse_hits(input logic pad, input logic [9:0] blks, input logic side);
        collide_paddle = pad;
        collide_blocks = blks;
        collide_side   = side;
        @(negedge clk);
        collide_paddle = 1'b0;
        collide_blocks = '0;
        collide_side   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; active_pixels = 1'b0; serve = 1'b0;
        speed_sel = '0; collide_paddle = 1'b0; collide_blocks = '0; collide_side = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset values and free-running tick phase
        check_eq("rst_state", 32'(state), 32'd0);
        check_ball("rst_ball", 310, 400);
        check_eq("rst_lost", 32'(ball_lost), 32'd0);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("ball_size", 32'(ball_size), 32'd20);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("tick_phase%0d", k), 32'(tick), (k % 4 == 3) ? 32'd1 : 32'd0);
        end

        // Ball pixel decode while parked
        active_pixels = 1'b1; x = 10'd310; y = 10'd400; #1;
        check_eq("idle_in_tl", 32'(in_ball), 32'd1);
        check_eq("idle_color", vga_color, 32'hFFFFFF);
        x = 10'd329; y = 10'd419; #1;
        check_eq("idle_in_br", 32'(in_ball), 32'd1);
        x = 10'd330; #1;
        check_eq("idle_out_r", 32'(in_ball), 32'd0);
        check_eq("idle_out_col", vga_color, 32'h0);
        x = 10'd309; y = 10'd400; #1;
        check_eq("idle_out_l", 32'(in_ball), 32'd0);
        x = 10'd310; active_pixels = 1'b0; #1;
        check_eq("idle_blank", 32'(in_ball), 32'd0);
        @(negedge clk);

        // Serve at speed 2
        do_serve(2'd1);
        check_eq("serve_state", 32'(state), 32'd1);
        run_ticks(1);
        check_ball("serve_t1", 312, 398);
        run_ticks(1);
        check_ball("serve_t2", 314, 396);

        // Speed 3: right wall clamp and turn-back
        do_reset();
        do_serve(2'd2);
        run_ticks(103);
        check_ball("wall_pre", 619, 91);
        run_ticks(1);
        check_ball("wall_clamp", 620, 88);
        run_ticks(1);
        check_ball("wall_back", 617, 85);

        // Paddle while moving up is ignored; serve in MOVE is ignored
        serve = 1'b1;
        speed_sel = 2'd0;
        pulse_hits(1'b1, '0, 1'b0);
        serve = 1'b0;
        run_ticks(1);
        check_ball("pad_up", 614, 82);
        check_eq("move_state", 32'(state), 32'd1);

        // Top wall bounce, then descend
        run_ticks(28);
        check_ball("top", 530, 0);
        run_ticks(6);
        check_ball("descend", 512, 18);

        // Paddle while moving down reflects upward
        pulse_hits(1'b1, '0, 1'b0);
        run_ticks(1);
        check_ball("pad_down", 509, 15);
        run_ticks(5);
        check_ball("top2", 494, 0);

        // Side block hit flips horizontal direction
        pulse_hits(1'b0, 10'b00_0000_0001, 1'b1);
        run_ticks(1);
        check_ball("blk_side", 497, 3);
        run_ticks(3);
        check_ball("dn_right", 506, 12);

        // Paddle plus side block in the same period
        pulse_hits(1'b1, 10'b00_0000_1000, 1'b1);
        run_ticks(1);
        check_ball("simul", 503, 9);

        // Top/bottom block hit flips vertical direction
        pulse_hits(1'b0, 10'b00_0010_0000, 1'b0);
        run_ticks(1);
        check_ball("blk_top", 500, 12);

        // Paddle hit landing in the tick cycle takes effect one tick later
        begin
            int guard = 0;
            while (tick !== 1'b1 && guard < 16) begin
                @(negedge clk);
                guard++;
            end
            check_eq("tick_seen", 32'(tick), 32'd1);
        end
        pulse_hits(1'b1, '0, 1'b0);
        check_ball("late_hit0", 497, 15);
        run_ticks(1);
        check_ball("late_hit1", 494, 12);

        // Lost ball at speed 2
        do_reset();
        do_serve(2'd1);
        run_ticks(429);
        check_ball("pre_lost", 72, 458);
        check_eq("pre_lost_st", 32'(state), 32'd1);
        run_ticks(1);
        check_ball("lost", 70, 460);
        check_eq("lost_state", 32'(state), 32'd2);
        check_eq("lost_pulse", 32'(ball_lost), 32'd1);
        active_pixels = 1'b1; x = 10'd70; y = 10'd460; #1;
        check_eq("lost_color", vga_color, 32'hFF0000);
        x = 10'd89; y = 10'd479; #1;
        check_eq("lost_in_br", 32'(in_ball), 32'd1);
        x = 10'd90; #1;
        check_eq("lost_out_col", vga_color, 32'h0);
        active_pixels = 1'b0;
        @(negedge clk);
        check_eq("lost_pulse_end", 32'(ball_lost), 32'd0);

        // Serve ignored while lost; re-park on the 60th tick
        do_serve(2'd3);
        run_ticks(59);
        check_eq("lost59_state", 32'(state), 32'd2);
        check_ball("lost59", 70, 460);
        check_eq("lost59_pulse", 32'(ball_lost), 32'd0);
        run_ticks(1);
        check_eq("repark_state", 32'(state), 32'd0);
        check_ball("repark", 310, 400);

        // Lose again, then asynchronous reset mid-LOST
        do_serve(2'd1);
        run_ticks(430);
        check_eq("lost2_state", 32'(state), 32'd2);
        run_ticks(10);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_ball("arst", 310, 400);
        check_eq("arst_lost", 32'(ball_lost), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_state", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised successor to the single-ball mover in the brick-breaker video path. It keeps a square ball on a configurable screen and advances it once per frame tick at a selectable speed. It adds a serve/lost state machine, a collision vector of any width with side-aware block reflection, and edge clamping for speeds above 1. It sits between the collision detectors (paddle, block array) and the VGA colour mux; its position outputs feed those detectors.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 20, ball edge length in pixels
- TICK_DIV, 416667, clk cycles per movement tick (60 Hz at 25 MHz)
- NUM_BLOCKS, 10, width of the block-collision vector
- START_X, 310 / START_Y, 400, park position (top-left corner)
- LOST_TICKS, 60, ticks spent in LOST before re-parking
- Reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- x, y  in  10 each  current scan pixel coordinate
- active_pixels  in  1  scan is in the visible region
- serve  in  1  launch request; honoured only in IDLE
- speed_sel  in  2  speed v = speed_sel+1 px/tick, sampled on serve
- collide_paddle  in  1  paddle overlap (any-cycle pulse)
- collide_blocks  in  NUM_BLOCKS  per-block overlap pulses
- collide_side  in  1  qualifies a block hit as a side hit
- vga_color  out  24  ball pixel colour, black elsewhere
- in_ball  out  1  scan pixel is inside the ball
- ball_x, ball_y  out  10 each  ball top-left, registered
- ball_size  out  10  constant BALL_SIZE
- state  out  2  0 IDLE, 1 MOVE, 2 LOST
- ball_lost  out  1  one-cycle pulse on entry to LOST
- tick  out  1  one-cycle movement-tick strobe

## Operation
- Reset values:
  - state IDLE; ball_x = START_X, ball_y = START_Y.
  - dx = right, dy = up, v = 1.
  - tick counter 0; tick 0; ball_lost 0.
  - All collision latches 0; lost counter 0.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick = 1 for the single cycle where the counter equals TICK_DIV-1. The counter free-runs in every state.
- Collision latches (paddle, block_any = OR of collide_blocks, side):
  - Off-tick cycles: latch |= input.
  - Tick cycles: latch <= input, so a hit arriving in the tick cycle counts toward the next tick.
- IDLE:
  - Ball is held at START.
  - serve = 1 → MOVE on the next clk, not tick-gated.
  - On that serve: v <= speed_sel+1, dx <= right, dy <= up.
- MOVE, on tick only. Steps run in this order.
  - Step 1, direction:
    - paddle latch with dy = down → dy = up. A paddle hit while moving up is ignored.
    - else block latch with side latch = 0 → flip dy.
    - block latch with side latch = 1 → flip dx.
    - Paddle takes priority over a block for dy. A block side hit can flip dx on the same tick as a paddle hit.
  - Step 2, step with the new direction, using 11-bit arithmetic:
    - Right: nx = ball_x+v. If nx ≥ SCREEN_W-BALL_SIZE, clamp to SCREEN_W-BALL_SIZE and set dx = left.
    - Left: if ball_x ≤ v, nx = 0 and dx = right; else nx = ball_x-v.
    - Up: if ball_y ≤ v, ny = 0 and dy = down; else ny = ball_y-v.
    - Down: ny = ball_y+v. If ny ≥ SCREEN_H-BALL_SIZE, clamp and go to LOST.
  - Wall clamps override the collision direction chosen in step 1.
  - serve is ignored in MOVE.
- LOST:
  - ball_lost pulses in the first LOST cycle.
  - The ball stays at the bottom clamp.
  - The lost counter counts ticks. At LOST_TICKS it re-parks the ball to START and returns to IDLE (dx right, dy up).
  - serve is ignored in LOST.
- Display (combinational from registers):
  - in_ball = active_pixels && ball_x ≤ x < ball_x+BALL_SIZE && ball_y ≤ y < ball_y+BALL_SIZE.
  - vga_color = 24'hFFFFFF in IDLE or MOVE, 24'hFF0000 in LOST, 0 when in_ball = 0.
- rst mid-operation returns everything to the reset values immediately, regardless of state.

## Timing
- ball_x / ball_y update in the tick cycle and are visible the following cycle. There is no extra lag stage.
- Collision-to-effect latency is at most one tick period.
- The serve → MOVE transition takes 1 clk. The first movement happens on the next tick.
- ball_lost is asserted in the cycle after the tick that reaches the bottom clamp.
- LOST → IDLE takes effect on the LOST_TICKS-th tick after entry.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset: hold rst high, release it, run 10 cycles → state 0, ball at (310,400), tick pulses every 4th cycle, ball_lost 0.
- Serve: speed_sel = 1, serve for 1 cycle → state 1. After tick 1 the ball is at (312,398); after tick 2 at (314,396).
- Right wall clamp: force ball_x = 618, dx right, v = 3 → next tick x = 620 and dx left; the tick after that gives x = 617.
- Paddle hit:
  - Moving down, pulse collide_paddle for 1 cycle mid-period → next tick dy = up and y decreases by v.
  - Moving up, pulse collide_paddle → no change.
- Simultaneous hit: collide_paddle with collide_blocks[3] and collide_side = 1 in the same period, moving down-right → dy up, dx left.
- Lost ball and reset:
  - Moving down with y = 458, v = 2 → y = 460, state 2, ball_lost pulses once, colour FF0000.
  - After 60 ticks → state 0 and ball at (310,400).
  - Assert rst mid-LOST → immediate IDLE.
